countdown_timer_ctrl: RTL

Programmable countdown timer controller for the lab board designs. It replaces divided-clock usage with single-cycle tick enables from an internal prescaler, all in the one system clock domain. An FSM sequences the prescaler and the down-counter through load, start, pause, clear and auto-reload. It drives display/LED logic with the count value, a done pulse and an alarm level.

---
 rtl/countdown_timer_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/countdown_timer_ctrl.sv
// Programmable countdown timer controller.
// An internal prescaler produces one-cycle tick enables in the system clock
// domain, and an FSM sequences load, start, pause, clear and auto-reload.
module countdown_timer_ctrl #(
    parameter int TICK_COUNT = 100_000_000,
    parameter int WIDTH      = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             running,
    output logic             tick,
    output logic             done_pulse,
    output logic             alarm
);

    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_COUNT - 1);
    localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_d;
    logic             done_d;

    assign state   = state_q;
    assign running = (state_q == RUN);
    assign alarm   = (state_q == DONE);

    // Next-state logic: commands resolve clear > pause > start > load, and
    // RUN advances the prescaler only when neither clear nor pause is present.
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = reload_q;
                end else if (pause) begin
                    state_d = IDLE;
                end else if (start) begin
                    if (count != '0) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end else if (load) begin
                    reload_d = load_value;
                    count_d  = load_value;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = reload_q;
                    presc_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (count == COUNT_ONE) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = DONE;
                        end
                    end else if (count != '0) begin
                        count_d = count - COUNT_ONE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = reload_q;
                    presc_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    state_d = IDLE;
                    count_d = reload_q;
                end else if (pause) begin
                    state_d = DONE;
                end else if (start) begin
                    if (reload_q != '0) begin
                        state_d = RUN;
                        count_d = reload_q;
                        presc_d = '0;
                    end
                end else if (load) begin
                    state_d  = IDLE;
                    reload_d = load_value;
                    count_d  = load_value;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            count      <= '0;
            reload_q   <= '0;
            presc_q    <= '0;
            tick       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            count      <= count_d;
            reload_q   <= reload_d;
            presc_q    <= presc_d;
            tick       <= tick_d;
            done_pulse <= done_d;
        end
    end

endmodule
